bp_cce_gpr_wb_arbiter: RTL

Arbitrates the single CCE GPR write port among three writers:
- microcode ALU/move writeback;
- directory RDE address writeback, queued in a small FIFO;
- a low-priority config/debug write path.

It produces the per-GPR write mask and write data consumed by the CCE register block. It also generates the microcode stall and provides a flush handshake that drains queued directory writes before a ucode context change.

---
 rtl/bp_cce_gpr_wb_arbiter_if.sv | 53 +++++
 rtl/bp_cce_gpr_wb_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bp_cce_gpr_wb_arbiter_if.sv
// Request/grant bundle between the CCE GPR writers and the GPR write-port arbiter.
// The arbiter connects to the slave modport. The writers and the register block connect to the master modport.
interface bp_cce_gpr_wb_arbiter_if #(
  parameter int gpr_width_p = 64,
  parameter int num_gpr_p   = 16
);
  localparam int sel_width_lp = $clog2(num_gpr_p);

  logic                    ucode_v_i;
  logic [sel_width_lp-1:0] ucode_sel_i;
  logic [gpr_width_p-1:0]  ucode_data_i;
  logic                    ucode_stall_o;

  logic                    dir_v_i;
  logic [sel_width_lp-1:0] dir_sel_i;
  logic [gpr_width_p-1:0]  dir_data_i;
  logic                    dir_ready_o;

  logic                    cfg_v_i;
  logic [sel_width_lp-1:0] cfg_sel_i;
  logic [gpr_width_p-1:0]  cfg_data_i;
  logic                    cfg_yumi_o;

  logic                    flush_i;
  logic                    flush_done_o;

  logic [num_gpr_p-1:0]    gpr_w_mask_o;
  logic [gpr_width_p-1:0]  gpr_w_data_o;

  modport slave (
    input  ucode_v_i, ucode_sel_i, ucode_data_i,
    output ucode_stall_o,
    input  dir_v_i, dir_sel_i, dir_data_i,
    output dir_ready_o,
    input  cfg_v_i, cfg_sel_i, cfg_data_i,
    output cfg_yumi_o,
    input  flush_i,
    output flush_done_o,
    output gpr_w_mask_o, gpr_w_data_o
  );

  modport master (
    output ucode_v_i, ucode_sel_i, ucode_data_i,
    input  ucode_stall_o,
    output dir_v_i, dir_sel_i, dir_data_i,
    input  dir_ready_o,
    output cfg_v_i, cfg_sel_i, cfg_data_i,
    input  cfg_yumi_o,
    output flush_i,
    input  flush_done_o,
    input  gpr_w_mask_o, gpr_w_data_o
  );
endinterface

// File: rtl/bp_cce_gpr_wb_arbiter.sv
// Arbitrates the single CCE GPR write port among ucode, queued directory writebacks and config writes.
// Optional macro BP_CCE_GPR_WB_BYPASS_EN lets a directory write skip an empty FIFO and be written in the same cycle.
module bp_cce_gpr_wb_arbiter #(
  parameter int gpr_width_p        = 64,
  parameter int num_gpr_p          = 16,
  parameter int dir_fifo_els_p     = 4,
  parameter int cfg_starve_limit_p = 8
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_cce_gpr_wb_arbiter_if.slave bus
);
  localparam int sel_width_lp    = $clog2(num_gpr_p);
  localparam int ptr_width_lp    = $clog2(dir_fifo_els_p);
  localparam int cnt_width_lp    = ptr_width_lp + 1;
  localparam int starve_width_lp = $clog2(cfg_starve_limit_p + 1);

  typedef enum logic [1:0] {e_run, e_flush, e_done} state_e;

  state_e                     state, state_n;
  logic [sel_width_lp-1:0]    fifo_sel  [dir_fifo_els_p];
  logic [gpr_width_p-1:0]     fifo_data [dir_fifo_els_p];
  logic [ptr_width_lp-1:0]    rd_ptr, wr_ptr;
  logic [cnt_width_lp-1:0]    count;
  logic [starve_width_lp-1:0] starve_cnt;

  logic empty, full, dir_ready, forced_cfg, enq, deq, flush_done;
  logic fifo_grant, byp_grant, ucode_grant, cfg_grant;
  logic                    w_v;
  logic [sel_width_lp-1:0] w_sel;
  logic [gpr_width_p-1:0]  w_data;

  assign empty      = (count == '0);
  assign full       = (count == cnt_width_lp'(dir_fifo_els_p));
  assign dir_ready  = reset_n_i && !full && (state != e_flush);
  assign forced_cfg = bus.cfg_v_i && (starve_cnt == starve_width_lp'(cfg_starve_limit_p));
  assign enq        = bus.dir_v_i && dir_ready && !byp_grant;
  assign deq        = fifo_grant;

  // One grant per cycle; all grants are held off while reset is asserted.
  always_comb begin
    fifo_grant  = 1'b0;
    byp_grant   = 1'b0;
    ucode_grant = 1'b0;
    cfg_grant   = 1'b0;
    if (reset_n_i) begin
      if (state == e_flush) fifo_grant = !empty;
      else if (forced_cfg)  cfg_grant  = 1'b1;
      else if (!empty)      fifo_grant = 1'b1;
`ifdef BP_CCE_GPR_WB_BYPASS_EN
      else if (bus.dir_v_i && dir_ready) byp_grant = 1'b1;
`endif
      else if (bus.ucode_v_i) ucode_grant = 1'b1;
      else if (bus.cfg_v_i)   cfg_grant   = 1'b1;
    end
  end

  always_comb begin
    w_v    = 1'b1;
    w_sel  = '0;
    w_data = '0;
    if (fifo_grant) begin
      w_sel  = fifo_sel[rd_ptr];
      w_data = fifo_data[rd_ptr];
    end else if (byp_grant) begin
      w_sel  = bus.dir_sel_i;
      w_data = bus.dir_data_i;
    end else if (ucode_grant) begin
      w_sel  = bus.ucode_sel_i;
      w_data = bus.ucode_data_i;
    end else if (cfg_grant) begin
      w_sel  = bus.cfg_sel_i;
      w_data = bus.cfg_data_i;
    end else begin
      w_v = 1'b0;
    end
  end

  assign bus.gpr_w_mask_o  = w_v ? (num_gpr_p'(1) << w_sel) : '0;
  assign bus.gpr_w_data_o  = w_data;
  assign bus.ucode_stall_o = reset_n_i && bus.ucode_v_i && !ucode_grant;
  assign bus.cfg_yumi_o    = cfg_grant;
  assign bus.dir_ready_o   = dir_ready;
  assign bus.flush_done_o  = flush_done;

  // An enqueue accepted in the cycle flush_i is seen belongs to the drain.
  always_comb begin
    state_n    = state;
    flush_done = 1'b0;
    case (state)
      e_run: begin
        if (bus.flush_i) state_n = (empty && !enq) ? e_done : e_flush;
      end
      e_flush: begin
        if (empty || (deq && count == cnt_width_lp'(1))) state_n = e_done;
      end
      e_done: begin
        flush_done = 1'b1;
        state_n    = e_run;
      end
      default: state_n = e_run;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= e_run;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_n;
      if (enq) wr_ptr <= wr_ptr + ptr_width_lp'(1);
      if (deq) rd_ptr <= rd_ptr + ptr_width_lp'(1);
      case ({enq, deq})
        2'b10:   count <= count + cnt_width_lp'(1);
        2'b01:   count <= count - cnt_width_lp'(1);
        default: count <= count;
      endcase
      // The starvation count is frozen while draining so cfg keeps its standing.
      if (state != e_flush) begin
        if (cfg_grant || !bus.cfg_v_i)
          starve_cnt <= '0;
        else if (starve_cnt != starve_width_lp'(cfg_starve_limit_p))
          starve_cnt <= starve_cnt + starve_width_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_sel[wr_ptr]  <= bus.dir_sel_i;
      fifo_data[wr_ptr] <= bus.dir_data_i;
    end
  end

`ifndef SYNTHESIS
  a_mask_onehot: assert property (@(posedge clk_i) $onehot0(bus.gpr_w_mask_o))
    else $error("gpr_w_mask_o is multi-hot");

  if (num_gpr_p < (1 << sel_width_lp)) begin : g_sel_chk
    a_ucode_sel: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      bus.ucode_v_i |-> (32'(bus.ucode_sel_i) < num_gpr_p)) else $error("ucode_sel_i out of range");
    a_dir_sel: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      bus.dir_v_i |-> (32'(bus.dir_sel_i) < num_gpr_p)) else $error("dir_sel_i out of range");
    a_cfg_sel: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      bus.cfg_v_i |-> (32'(bus.cfg_sel_i) < num_gpr_p)) else $error("cfg_sel_i out of range");
  end
`endif
endmodule
